// File: rtl/afe_ro_cfg_bridge.sv
// -----------------------------------------------------------------------------
// afe_ro_cfg_bridge
//   APB-to-AFE configuration bridge for the AFE readout subsystem.
//   Each APB access is decoded on its address select field:
//     - select < NUM_AFE       : registered request to that AFE cfg port. The
//                                bridge waits for cfg_ready_i and aborts with
//                                PSLVERR once the programmable timeout expires.
//     - select == 2**SEL_W-1   : internal register file (uDMA shutdown,
//                                per-AFE clock enables, timeout, sticky status).
//     - any other select       : one-cycle error response, no side effects.
//   One pulp_clock_gating cell per AFE produces afe_top_clk_o.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   test_mode_i          forces all AFE clock gates open
//   apb_*                APB slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PREADY/
//                        PSLVERR/PRDATA); rdata/slverr are zero unless ready
//   cfg_addr_o/wdata_o   registered word offset and write data to the AFEs
//   cfg_valid_o          one-hot request, high only while waiting for the ack
//   cfg_ready_i          per-AFE ack; cfg_rdata_i sampled together with it
//   cfg_rwn_o            1 = read, 0 = write
//   udma_shtdwn_o        uDMA shutdown request (UDMA_CFG bit 0)
//   afe_top_clk_o        gated per-AFE clocks
//   to_err_o             one-cycle pulse (during the response) on timeout abort
// -----------------------------------------------------------------------------
module afe_ro_cfg_bridge #(
  parameter int unsigned NUM_AFE        = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned SEL_LSB        = 10,
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned TO_WIDTH       = 16,
  parameter int unsigned TO_DEFAULT     = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            test_mode_i,
  input  logic                            apb_sel_i,
  input  logic                            apb_en_i,
  input  logic                            apb_write_i,
  input  logic [APB_ADDR_WIDTH-1:0]       apb_address_i,
  input  logic [31:0]                     apb_wdata_i,
  output logic                            apb_ready_o,
  output logic                            apb_slverr_o,
  output logic [31:0]                     apb_rdata_o,
  output logic [SEL_LSB-3:0]              cfg_addr_o,
  output logic [31:0]                     cfg_wdata_o,
  output logic [NUM_AFE-1:0]              cfg_valid_o,
  input  logic [NUM_AFE-1:0]              cfg_ready_i,
  output logic                            cfg_rwn_o,
  input  logic [NUM_AFE-1:0][31:0]        cfg_rdata_i,
  output logic                            udma_shtdwn_o,
  output logic [NUM_AFE-1:0]              afe_top_clk_o,
  output logic                            to_err_o
);

  localparam int unsigned OFF_W = SEL_LSB - 2;

  localparam logic [OFF_W-1:0] OFF_UDMA    = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_CG      = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_TIMEOUT = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_STATUS  = OFF_W'(3);

  localparam logic [SEL_W-1:0] SEL_INT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [SEL_W-1:0]     r_sel;
  logic [OFF_W-1:0]     r_addr;
  logic [31:0]          r_wdata;
  logic                 r_rwn;
  logic [TO_WIDTH-1:0]  r_cnt;
  logic [31:0]          r_rdata;
  logic                 r_slverr;
  logic                 r_to_err;
  logic                 r_udma;
  logic [NUM_AFE-1:0]   r_cg;
  logic [TO_WIDTH-1:0]  r_timeout;
  logic [NUM_AFE-1:0]   r_status;

  logic                 w_access;
  logic [SEL_W-1:0]     w_sel_in;
  logic [OFF_W-1:0]     w_off_in;
  logic                 w_cap;
  logic                 w_int_acc;
  logic                 w_bad;
  logic                 w_afe_ok;
  logic                 w_abort;
  logic                 w_to_hit;
  logic                 w_afe_rdy;
  logic [31:0]          w_afe_rdata;
  logic [NUM_AFE-1:0]   w_sel_oh;
  logic [31:0]          w_int_rd;
  logic [NUM_AFE-1:0]   w_w1c;
  logic [NUM_AFE-1:0]   w_set;
  logic                 w_unused;

  assign w_access = apb_sel_i & apb_en_i;
  assign w_sel_in = apb_address_i[SEL_LSB +: SEL_W];
  assign w_off_in = apb_address_i[SEL_LSB-1:2];
  assign w_unused = ^{apb_address_i[1:0], apb_address_i[APB_ADDR_WIDTH-1:SEL_LSB+SEL_W]};

  // Select-indexed views of the AFE side; r_sel may exceed NUM_AFE-1 outside REQ.
  always_comb begin
    w_sel_oh    = '0;
    w_afe_rdy   = 1'b0;
    w_afe_rdata = '0;
    for (int unsigned i = 0; i < NUM_AFE; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_afe_rdy   = cfg_ready_i[i];
        w_afe_rdata = cfg_rdata_i[i];
      end
    end
  end

  assign w_to_hit = (r_timeout != '0) && (r_cnt == r_timeout);

  always_comb begin
    w_int_rd = '0;
    case (w_off_in)
      OFF_UDMA:    w_int_rd[0]            = r_udma;
      OFF_CG:      w_int_rd[NUM_AFE-1:0]  = r_cg;
      OFF_TIMEOUT: w_int_rd[TO_WIDTH-1:0] = r_timeout;
      // bit31 (busy) reads 0: the APB is stalled whenever the bridge is busy
      OFF_STATUS:  w_int_rd[NUM_AFE-1:0]  = r_status;
      default:     w_int_rd               = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cap        = 1'b0;
    w_int_acc    = 1'b0;
    w_bad        = 1'b0;
    w_afe_ok     = 1'b0;
    w_abort      = 1'b0;
    apb_ready_o  = 1'b0;
    apb_rdata_o  = '0;
    apb_slverr_o = 1'b0;
    cfg_valid_o  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_cap = 1'b1;
          if (w_sel_in < SEL_W'(NUM_AFE)) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_RESP;
            if (w_sel_in == SEL_INT) w_int_acc = 1'b1;
            else                     w_bad     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cfg_valid_o = w_sel_oh;
        // ack takes priority over a timeout expiring in the same cycle
        if (w_afe_rdy) begin
          w_afe_ok    = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        apb_ready_o  = 1'b1;
        apb_rdata_o  = r_rdata;
        apb_slverr_o = r_slverr;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_w1c = (w_int_acc && apb_write_i && (w_off_in == OFF_STATUS)) ?
                 apb_wdata_i[NUM_AFE-1:0] : '0;
  assign w_set = w_abort ? w_sel_oh : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rwn     <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_to_err  <= 1'b0;
      r_udma    <= 1'b0;
      r_cg      <= '0;
      r_timeout <= TO_WIDTH'(TO_DEFAULT);
      r_status  <= '0;
    end else begin
      r_to_err <= w_abort;
      // set wins over a clear of the same bit
      r_status <= (r_status & ~w_w1c) | w_set;

      if (w_cap) begin
        r_sel   <= w_sel_in;
        r_addr  <= w_off_in;
        r_wdata <= apb_wdata_i;
        r_rwn   <= ~apb_write_i;
        r_cnt   <= TO_WIDTH'(1);
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + TO_WIDTH'(1);
      end

      if (w_int_acc) begin
        r_rdata  <= apb_write_i ? '0 : w_int_rd;
        r_slverr <= 1'b0;
        if (apb_write_i) begin
          case (w_off_in)
            OFF_UDMA:    r_udma    <= apb_wdata_i[0];
            OFF_CG:      r_cg      <= apb_wdata_i[NUM_AFE-1:0];
            OFF_TIMEOUT: r_timeout <= apb_wdata_i[TO_WIDTH-1:0];
            default:     ;
          endcase
        end
      end

      if (w_bad) begin
        r_rdata  <= '0;
        r_slverr <= 1'b1;
      end

      if (w_afe_ok) begin
        r_rdata  <= r_rwn ? w_afe_rdata : '0;
        r_slverr <= 1'b0;
      end

      if (w_abort) begin
        r_rdata  <= '0;
        r_slverr <= 1'b1;
      end
    end
  end

  assign cfg_addr_o    = r_addr;
  assign cfg_wdata_o   = r_wdata;
  assign cfg_rwn_o     = r_rwn;
  assign udma_shtdwn_o = r_udma;
  assign to_err_o      = r_to_err;

  for (genvar g = 0; g < NUM_AFE; g++) begin : g_cg
    pulp_clock_gating u_cg (
      .clk_i     (clk_i),
      .en_i      (r_cg[g]),
      .test_en_i (test_mode_i),
      .clk_o     (afe_top_clk_o[g])
    );
  end

endmodule

// -----------------------------------------------------------------------------
// pulp_clock_gating
//   Latch-based glitch-free clock gate: enable is captured while clk_i is low.
//   Ports: clk_i clock in, en_i enable, test_en_i test override, clk_o gated clock.
// -----------------------------------------------------------------------------
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_clk_en;

  always_latch begin
    if (!clk_i) r_clk_en <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_clk_en;

endmodule

// File: tb/tb_afe_ro_cfg_bridge.sv
// -----------------------------------------------------------------------------
// tb_afe_ro_cfg_bridge
//   Directed bench for afe_ro_cfg_bridge (NUM_AFE=4, SEL_LSB=10, SEL_W=3).
//   Inputs are driven and outputs sampled on the falling clock edge; the gated
//   clocks are sampled shortly after the rising edge.
//   AFE i returns read data 0xCAFE000i.
// -----------------------------------------------------------------------------
module tb_afe_ro_cfg_bridge;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              test_mode_i;
  logic              apb_sel_i;
  logic              apb_en_i;
  logic              apb_write_i;
  logic [31:0]       apb_address_i;
  logic [31:0]       apb_wdata_i;
  logic              apb_ready_o;
  logic              apb_slverr_o;
  logic [31:0]       apb_rdata_o;
  logic [7:0]        cfg_addr_o;
  logic [31:0]       cfg_wdata_o;
  logic [3:0]        cfg_valid_o;
  logic [3:0]        cfg_ready_i;
  logic              cfg_rwn_o;
  logic [3:0][31:0]  cfg_rdata_i;
  logic              udma_shtdwn_o;
  logic [3:0]        afe_top_clk_o;
  logic              to_err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  afe_ro_cfg_bridge #(
    .NUM_AFE        (4),
    .APB_ADDR_WIDTH (32),
    .SEL_LSB        (10),
    .SEL_W          (3),
    .TO_WIDTH       (16),
    .TO_DEFAULT     (1024)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .test_mode_i   (test_mode_i),
    .apb_sel_i     (apb_sel_i),
    .apb_en_i      (apb_en_i),
    .apb_write_i   (apb_write_i),
    .apb_address_i (apb_address_i),
    .apb_wdata_i   (apb_wdata_i),
    .apb_ready_o   (apb_ready_o),
    .apb_slverr_o  (apb_slverr_o),
    .apb_rdata_o   (apb_rdata_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_valid_o   (cfg_valid_o),
    .cfg_ready_i   (cfg_ready_i),
    .cfg_rwn_o     (cfg_rwn_o),
    .cfg_rdata_i   (cfg_rdata_i),
    .udma_shtdwn_o (udma_shtdwn_o),
    .afe_top_clk_o (afe_top_clk_o),
    .to_err_o      (to_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer. rdy_cyc = REQ cycle (1-based) in which AFE rdy_idx acks,
  // 0 = never. lat counts falling edges from the access cycle to PREADY.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int rdy_cyc, input int rdy_idx,
                      output logic [31:0] rd, output logic err, output int lat,
                      output int vcnt, output logic [3:0] vfirst, output int tocnt,
                      output logic got);
    @(negedge clk_i);
    apb_sel_i = 1'b1; apb_en_i = 1'b0; apb_write_i = wr;
    apb_address_i = addr; apb_wdata_i = wd;
    @(negedge clk_i);
    apb_en_i = 1'b1;
    lat = 0; vcnt = 0; vfirst = '0; tocnt = 0; got = 1'b0; rd = '0; err = 1'b0;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(negedge clk_i);
      lat = n;
      cfg_ready_i = '0;
      if (rdy_cyc == n) cfg_ready_i[rdy_idx] = 1'b1;
      if (cfg_valid_o != '0) begin
        if (vcnt == 0) vfirst = cfg_valid_o;
        vcnt++;
      end
      if (to_err_o) tocnt++;
      if (apb_ready_o) begin
        got = 1'b1; rd = apb_rdata_o; err = apb_slverr_o;
        apb_sel_i = 1'b0; apb_en_i = 1'b0;
      end
    end
    cfg_ready_i = '0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          vcnt;
  logic [3:0]  vf;
  int          tocnt;
  logic        got;

  initial begin
    rst_ni = 1'b0; test_mode_i = 1'b0;
    apb_sel_i = 1'b0; apb_en_i = 1'b0; apb_write_i = 1'b0;
    apb_address_i = '0; apb_wdata_i = '0; cfg_ready_i = '0;
    for (int i = 0; i < 4; i++) cfg_rdata_i[i] = 32'hCAFE0000 | i;

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready",  {31'd0, apb_ready_o},   32'd0);
    chk("rst_slverr", {31'd0, apb_slverr_o},  32'd0);
    chk("rst_rdata",  apb_rdata_o,            32'd0);
    chk("rst_valid",  {28'd0, cfg_valid_o},   32'd0);
    chk("rst_udma",   {31'd0, udma_shtdwn_o}, 32'd0);
    chk("rst_toerr",  {31'd0, to_err_o},      32'd0);
    @(posedge clk_i); #1;
    chk("rst_afeclk", {28'd0, afe_top_clk_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    xfer(1'b0, 32'h1C08, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("to_default", rd, 32'h400);
    chk("to_def_lat", lat, 32'd1);

    // T1: AFE_CG write/read, clock gating
    xfer(1'b1, 32'h1C04, 32'h3, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("cg_wr_lat", lat, 32'd1);
    chk("cg_wr_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 32'h1C04, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("cg_rd", rd, 32'h3);
    chk("cg_rd_lat", lat, 32'd1);
    @(posedge clk_i); #1;
    chk("afeclk_hi", {28'd0, afe_top_clk_o}, 32'h3);
    @(negedge clk_i); #1;
    chk("afeclk_lo", {28'd0, afe_top_clk_o}, 32'h0);
    test_mode_i = 1'b1;
    @(posedge clk_i); #1;
    chk("afeclk_test", {28'd0, afe_top_clk_o}, 32'hF);
    test_mode_i = 1'b0;

    xfer(1'b1, 32'h1C00, 32'h1, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("udma_out", {31'd0, udma_shtdwn_o}, 32'd1);
    xfer(1'b0, 32'h1C00, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("udma_rd", rd, 32'h1);

    // T2: AFE2 read, offset 0x10, ack on 5th REQ cycle
    xfer(1'b0, 32'h0840, 32'h0, 5, 2, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t2_got",   {31'd0, got}, 32'd1);
    chk("t2_rdata", rd, 32'hCAFE0002);
    chk("t2_err",   {31'd0, err}, 32'd0);
    chk("t2_lat",   lat, 32'd6);
    chk("t2_vcnt",  vcnt, 32'd5);
    chk("t2_valid", {28'd0, vf}, 32'h4);
    chk("t2_addr",  {24'd0, cfg_addr_o}, 32'h10);
    chk("t2_rwn",   {31'd0, cfg_rwn_o}, 32'd1);
    chk("t2_toerr", tocnt, 32'd0);

    // AFE3 write, offset 0x05, ack on first REQ cycle: write latches rdata 0
    xfer(1'b1, 32'h0C14, 32'h12345678, 1, 3, rd, err, lat, vcnt, vf, tocnt, got);
    chk("w3_rdata", rd, 32'h0);
    chk("w3_lat",   lat, 32'd2);
    chk("w3_valid", {28'd0, vf}, 32'h8);
    chk("w3_wdata", cfg_wdata_o, 32'h12345678);
    chk("w3_addr",  {24'd0, cfg_addr_o}, 32'h05);
    chk("w3_rwn",   {31'd0, cfg_rwn_o}, 32'd0);

    // T3: TIMEOUT=8, AFE1 never acks
    xfer(1'b1, 32'h1C08, 32'h8, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    xfer(1'b0, 32'h0408, 32'h0, 0, 1, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t3_err",   {31'd0, err}, 32'd1);
    chk("t3_rdata", rd, 32'h0);
    chk("t3_lat",   lat, 32'd9);
    chk("t3_vcnt",  vcnt, 32'd8);
    chk("t3_valid", {28'd0, vf}, 32'h2);
    chk("t3_toerr", tocnt, 32'd1);
    xfer(1'b0, 32'h1C0C, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t3_status", rd, 32'h2);
    xfer(1'b1, 32'h1C0C, 32'h2, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    xfer(1'b0, 32'h1C0C, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t3_w1c", rd, 32'h0);

    // T4: TIMEOUT=4, ack on the 4th cycle beats the timeout
    xfer(1'b1, 32'h1C08, 32'h4, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    xfer(1'b0, 32'h0000, 32'h0, 4, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t4_err",   {31'd0, err}, 32'd0);
    chk("t4_rdata", rd, 32'hCAFE0000);
    chk("t4_lat",   lat, 32'd5);
    chk("t4_toerr", tocnt, 32'd0);
    xfer(1'b0, 32'h1C0C, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t4_status0", rd, 32'h0);
    xfer(1'b0, 32'h0000, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t4_abort_err", {31'd0, err}, 32'd1);
    chk("t4_abort_lat", lat, 32'd5);
    // late ack two cycles after the abort must be ignored
    @(negedge clk_i);
    @(negedge clk_i);
    cfg_ready_i = 4'b0001;
    @(negedge clk_i);
    chk("t4_late_ready", {31'd0, apb_ready_o}, 32'd0);
    chk("t4_late_valid", {28'd0, cfg_valid_o}, 32'd0);
    cfg_ready_i = '0;
    xfer(1'b0, 32'h1C0C, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t4_status1", rd, 32'h1);

    // T5: unmapped selects and unmapped internal offset
    xfer(1'b0, 32'h1400, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("sel5_err",  {31'd0, err}, 32'd1);
    chk("sel5_lat",  lat, 32'd1);
    chk("sel5_vcnt", vcnt, 32'd0);
    xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("sel4_err",  {31'd0, err}, 32'd1);
    xfer(1'b0, 32'h1CFC, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("off3f_rd",  rd, 32'h0);
    chk("off3f_err", {31'd0, err}, 32'd0);
    xfer(1'b1, 32'h1CFC, 32'hFFFFFFFF, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    xfer(1'b0, 32'h1C04, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("cg_intact", rd, 32'h3);
    xfer(1'b0, 32'h1C08, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("to_intact", rd, 32'h4);

    // TIMEOUT=0 waits indefinitely
    xfer(1'b1, 32'h1C08, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    xfer(1'b0, 32'h0800, 32'h0, 20, 2, rd, err, lat, vcnt, vf, tocnt, got);
    chk("to0_err", {31'd0, err}, 32'd0);
    chk("to0_lat", lat, 32'd21);
    chk("to0_rd",  rd, 32'hCAFE0002);

    // T6: reset during REQ
    @(negedge clk_i);
    apb_sel_i = 1'b1; apb_en_i = 1'b0; apb_write_i = 1'b0; apb_address_i = 32'h0408;
    @(negedge clk_i);
    apb_en_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t6_valid_pre", {28'd0, cfg_valid_o}, 32'h2);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_valid_rst", {28'd0, cfg_valid_o}, 32'h0);
    chk("t6_ready_rst", {31'd0, apb_ready_o}, 32'd0);
    apb_sel_i = 1'b0; apb_en_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    xfer(1'b0, 32'h1C08, 32'h0, 0, 0, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t6_timeout", rd, 32'h400);
    chk("t6_udma", {31'd0, udma_shtdwn_o}, 32'd0);
    xfer(1'b0, 32'h0408, 32'h0, 2, 1, rd, err, lat, vcnt, vf, tocnt, got);
    chk("t6_rd",  rd, 32'hCAFE0001);
    chk("t6_lat", lat, 32'd3);
    chk("t6_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
